// File: rtl/fir_out_decim_sat.sv
// fir_out_decim_sat: decimates a full-precision FIR stream, rounds half-up, saturates,
// and buffers the result in a show-ahead FIFO toward a back-pressuring consumer.
module fir_out_decim_sat #(
    parameter int IN_WIDTH   = 24,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 8,
    parameter int DECIM      = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid_in,
    input  logic signed [IN_WIDTH-1:0]    din,
    output logic                          valid_out,
    output logic signed [OUT_WIDTH-1:0]   dout,
    input  logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          overflow,
    output logic                          saturated
);
    localparam int PW = DECIM > 1 ? $clog2(DECIM) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic signed [IN_WIDTH:0] RND  = SHIFT > 0 ? (IN_WIDTH+1)'(2**(SHIFT > 0 ? SHIFT-1 : 0)) : '0;
    localparam logic signed [IN_WIDTH:0] MAXV = (IN_WIDTH+1)'(2**(OUT_WIDTH-1)-1);
    localparam logic signed [IN_WIDTH:0] MINV = (IN_WIDTH+1)'(-(2**(OUT_WIDTH-1)));

    logic [PW-1:0]             phase_q, phase_d;
    logic signed [IN_WIDTH:0]  s1_q, s1_d;
    logic                      s1_v_q, keep;
    logic [OUT_WIDTH-1:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]             rd_q, wr_q;
    logic [AW:0]               cnt_q, cnt_d;
    logic                      clip_hi, clip_lo, pop, full, wr_en;
    logic [OUT_WIDTH-1:0]      s2;

    always_comb begin
        keep      = valid_in && phase_q == '0;
        phase_d   = !valid_in ? phase_q : phase_q == PW'(DECIM-1) ? '0 : phase_q + 1'b1;
        // one guard bit above the input keeps the rounding add from wrapping at max positive
        s1_d      = ($signed({din[IN_WIDTH-1], din}) + RND) >>> SHIFT;
        clip_hi   = s1_q > MAXV;
        clip_lo   = s1_q < MINV;
        s2        = clip_hi ? MAXV[OUT_WIDTH-1:0] : clip_lo ? MINV[OUT_WIDTH-1:0] : s1_q[OUT_WIDTH-1:0];
        valid_out = cnt_q != '0;
        full      = cnt_q == (AW+1)'(FIFO_DEPTH);
        pop       = valid_out && ready;
        wr_en     = s1_v_q && (!full || pop);
        cnt_d     = cnt_q + (AW+1)'(wr_en) - (AW+1)'(pop);
        // when empty, the slot just behind the read pointer holds the last delivered sample
        dout      = valid_out ? mem_q[rd_q] : mem_q[rd_q - 1'b1];
        fill_level = cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q   <= '0;
            s1_q      <= '0;
            s1_v_q    <= 1'b0;
            rd_q      <= '0;
            wr_q      <= '0;
            cnt_q     <= '0;
            overflow  <= 1'b0;
            saturated <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            phase_q   <= phase_d;
            s1_v_q    <= keep;
            if (keep) s1_q <= s1_d;
            if (wr_en) begin
                mem_q[wr_q] <= s2;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            cnt_q     <= cnt_d;
            overflow  <= overflow | (s1_v_q && full && !pop);
            saturated <= saturated | (s1_v_q && (clip_hi || clip_lo));
        end
    end
endmodule
